// File: rtl/channelif_rr_if.sv
// channelif_rr_if: platform stream, per-channel streams and status of channelif_rr
interface channelif_rr_if #(
    parameter int NCH = 6,
    parameter int DW  = 8,
    parameter int AW  = 4
);
    logic [DW-1:0]     in_data;
    logic              in_sof;
    logic              in_eof;
    logic              in_src_rdy;
    logic              in_dst_rdy;
    logic [AW-1:0]     inport_addr;
    logic [NCH*DW-1:0] ch_out_data;
    logic [NCH-1:0]    ch_out_sof;
    logic [NCH-1:0]    ch_out_eof;
    logic [NCH-1:0]    ch_out_src_rdy;
    logic [NCH-1:0]    ch_out_dst_rdy;
    logic [NCH*DW-1:0] ch_in_data;
    logic [NCH-1:0]    ch_in_sof;
    logic [NCH-1:0]    ch_in_eof;
    logic [NCH-1:0]    ch_in_src_rdy;
    logic [NCH-1:0]    ch_in_dst_rdy;
    logic [DW-1:0]     out_data;
    logic              out_sof;
    logic              out_eof;
    logic              out_src_rdy;
    logic              out_dst_rdy;
    logic [AW-1:0]     outport_addr;
    logic [NCH-1:0]    wenables;
    logic [NCH-1:0]    renables;
    logic [15:0]       drop_count;

    modport master (
        output in_data, in_sof, in_eof, in_src_rdy, inport_addr, ch_out_dst_rdy,
               ch_in_data, ch_in_sof, ch_in_eof, ch_in_src_rdy, out_dst_rdy,
        input  in_dst_rdy, ch_out_data, ch_out_sof, ch_out_eof, ch_out_src_rdy,
               ch_in_dst_rdy, out_data, out_sof, out_eof, out_src_rdy,
               outport_addr, wenables, renables, drop_count
    );

    modport slave (
        input  in_data, in_sof, in_eof, in_src_rdy, inport_addr, ch_out_dst_rdy,
               ch_in_data, ch_in_sof, ch_in_eof, ch_in_src_rdy, out_dst_rdy,
        output in_dst_rdy, ch_out_data, ch_out_sof, ch_out_eof, ch_out_src_rdy,
               ch_in_dst_rdy, out_data, out_sof, out_eof, out_src_rdy,
               outport_addr, wenables, renables, drop_count
    );
endinterface

// File: rtl/channelif_rr.sv
// channelif_rr: address-steered downstream demux and frame-atomic round-robin upstream mux
module channelif_rr #(
    parameter int NCH  = 6,
    parameter int DW   = 8,
    parameter int AW   = 4,
    parameter int BASE = 1
) (
    input logic           clk,
    input logic           rst,
    channelif_rr_if.slave bus
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {D_IDLE, D_ROUTE, D_DROP} dstate_t;
    typedef enum logic {U_IDLE, U_GRANT} ustate_t;

    dstate_t       d_state_q, d_state_d;
    logic [CW-1:0] d_ch_q, d_ch_d, d_sel;
    logic [15:0]   drop_q, drop_d;
    logic [AW:0]   diff;
    logic          addr_ok, d_route, d_xfer;

    ustate_t       u_state_q, u_state_d;
    logic [CW-1:0] g_q, g_d, ptr_q, ptr_d, pick, cand;
    logic [AW-1:0] oaddr_q, oaddr_d;
    logic [NCH-1:0] req;
    logic          found, u_gnt;

    // an address below BASE wraps negative and sets the extra top bit
    assign diff    = {1'b0, bus.inport_addr} - (AW+1)'(BASE);
    assign addr_ok = !diff[AW] && (diff < (AW+1)'(NCH));
    assign d_xfer  = bus.in_src_rdy && bus.in_dst_rdy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            d_state_q <= D_IDLE;
            d_ch_q    <= '0;
            drop_q    <= '0;
        end else begin
            d_state_q <= d_state_d;
            d_ch_q    <= d_ch_d;
            drop_q    <= drop_d;
        end
    end

    always_comb begin
        d_state_d = d_state_q;
        d_ch_d    = d_ch_q;
        drop_d    = drop_q;
        if (d_state_q == D_IDLE) begin
            if (d_xfer && bus.in_sof && addr_ok) begin
                d_ch_d    = d_sel;
                d_state_d = bus.in_eof ? D_IDLE : D_ROUTE;
            end else if (d_xfer && bus.in_sof) begin
                drop_d    = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
                d_state_d = bus.in_eof ? D_IDLE : D_DROP;
            end
        end else if (d_xfer && bus.in_eof) begin
            d_state_d = D_IDLE;
        end
    end

    always_comb begin
        d_sel              = (d_state_q == D_ROUTE) ? d_ch_q : diff[CW-1:0];
        d_route            = (d_state_q == D_ROUTE) ||
                             (d_state_q == D_IDLE && bus.in_src_rdy && bus.in_sof && addr_ok);
        bus.wenables       = d_route ? NCH'(1) << d_sel : '0;
        bus.in_dst_rdy     = d_route ? bus.ch_out_dst_rdy[d_sel] : (d_state_q == D_DROP) || bus.in_src_rdy;
        bus.ch_out_data    = {NCH{bus.in_data}};
        bus.ch_out_src_rdy = bus.wenables & {NCH{bus.in_src_rdy}};
        bus.ch_out_sof     = bus.wenables & {NCH{bus.in_src_rdy && bus.in_sof}};
        bus.ch_out_eof     = bus.wenables & {NCH{bus.in_src_rdy && bus.in_eof}};
    end

    assign bus.drop_count   = drop_q;
    assign req              = bus.ch_in_src_rdy & bus.ch_in_sof;
    assign bus.outport_addr = oaddr_q;

    // search starts just after the last winner so every requester gets its turn
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        cand  = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = CW'((int'(ptr_q) + k) % NCH);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            u_state_q <= U_IDLE;
            g_q       <= '0;
            ptr_q     <= CW'(NCH - 1);
            oaddr_q   <= '0;
        end else begin
            u_state_q <= u_state_d;
            g_q       <= g_d;
            ptr_q     <= ptr_d;
            oaddr_q   <= oaddr_d;
        end
    end

    always_comb begin
        u_state_d = u_state_q;
        g_d       = g_q;
        ptr_d     = ptr_q;
        oaddr_d   = oaddr_q;
        if (u_state_q == U_IDLE && found) begin
            u_state_d = U_GRANT;
            g_d       = pick;
            ptr_d     = pick;
            oaddr_d   = AW'(BASE) + AW'(pick);
        end else if (u_state_q == U_GRANT && bus.ch_in_src_rdy[g_q] && bus.out_dst_rdy && bus.ch_in_eof[g_q]) begin
            u_state_d = U_IDLE;
        end
    end

    always_comb begin
        u_gnt             = u_state_q == U_GRANT;
        bus.renables      = u_gnt ? NCH'(1) << g_q : '0;
        bus.ch_in_dst_rdy = bus.renables & {NCH{bus.out_dst_rdy}};
        bus.out_data      = u_gnt ? bus.ch_in_data[g_q*DW +: DW] : '0;
        bus.out_sof       = u_gnt && bus.ch_in_sof[g_q];
        bus.out_eof       = u_gnt && bus.ch_in_eof[g_q];
        bus.out_src_rdy   = u_gnt && bus.ch_in_src_rdy[g_q];
    end
endmodule

// File: tb/tb_channelif_rr.sv
// tb_channelif_rr: directed vectors and frame sequences for channelif_rr (NCH=6, BASE=1)
module tb_channelif_rr;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nchk = 0;
    int   nerr = 0;
    int   cyc  = 0;
    int   pos[6];
    int   len[6];

    typedef struct {
        logic       sof, eof, src;
        logic [3:0] addr;
        logic [7:0] data;
        logic [5:0] rdy;
        logic       dst;
        logic [5:0] wen, osrc, osof, oeof;
        logic [15:0] drop;
    } dvec_t;

    typedef struct {
        int         cyc;
        logic [3:0] addr;
        logic [7:0] data;
        logic       sof, eof;
    } ubeat_t;

    dvec_t  tbl[18];
    ubeat_t lg[$];
    ubeat_t ex[$];
    logic [5:0] last_ren;
    logic [3:0] last_oaddr;
    logic       last_osrc;

    channelif_rr_if #(.NCH(6), .DW(8), .AW(4)) bus ();
    channelif_rr #(.NCH(6), .DW(8), .AW(4), .BASE(1)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " in_dst_rdy"}, 64'(bus.in_dst_rdy), 64'd0);
        chk({tag, " wenables"}, 64'(bus.wenables), 64'd0);
        chk({tag, " renables"}, 64'(bus.renables), 64'd0);
        chk({tag, " ch_out_src_rdy"}, 64'(bus.ch_out_src_rdy), 64'd0);
        chk({tag, " ch_in_dst_rdy"}, 64'(bus.ch_in_dst_rdy), 64'd0);
        chk({tag, " out_src_rdy/sof/eof"}, 64'({bus.out_src_rdy, bus.out_sof, bus.out_eof}), 64'd0);
        chk({tag, " out_data"}, 64'(bus.out_data), 64'd0);
        chk({tag, " outport_addr"}, 64'(bus.outport_addr), 64'd0);
        chk({tag, " drop_count"}, 64'(bus.drop_count), 64'd0);
    endtask

    task automatic up_step(input logic rdy);
        logic [5:0] taken;
        logic       act;
        @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            act = pos[c] < len[c];
            bus.ch_in_src_rdy[c] = act;
            bus.ch_in_sof[c] = act && pos[c] == 0;
            bus.ch_in_eof[c] = act && pos[c] == len[c] - 1;
            bus.ch_in_data[c*8 +: 8] = {4'(c), 4'(pos[c])};
        end
        bus.out_dst_rdy = rdy;
        #1;
        last_ren   = bus.renables;
        last_oaddr = bus.outport_addr;
        last_osrc  = bus.out_src_rdy;
        if (bus.out_src_rdy && bus.out_dst_rdy)
            lg.push_back('{cyc, bus.outport_addr, bus.out_data, bus.out_sof, bus.out_eof});
        taken = bus.ch_in_dst_rdy & bus.ch_in_src_rdy;
        @(posedge clk);
        for (int c = 0; c < 6; c++) if (taken[c]) pos[c]++;
        cyc++;
    endtask

    task automatic add_beat(input int cy, input int ch, input int b, input logic s, input logic e);
        ex.push_back('{cy, 4'(ch + 1), {4'(ch), 4'(b)}, s, e});
    endtask

    task automatic cmp_log(input string tag);
        int n;
        chk({tag, " beat count"}, 64'(lg.size()), 64'(ex.size()));
        n = (lg.size() < ex.size()) ? lg.size() : ex.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s beat%0d cyc/addr/data/sof/eof", tag, i),
                64'({8'(lg[i].cyc), lg[i].addr, lg[i].data, lg[i].sof, lg[i].eof}),
                64'({8'(ex[i].cyc), ex[i].addr, ex[i].data, ex[i].sof, ex[i].eof}));
    endtask

    task automatic clear_inputs();
        bus.in_data = '0; bus.in_sof = 1'b0; bus.in_eof = 1'b0; bus.in_src_rdy = 1'b0;
        bus.inport_addr = '0; bus.ch_out_dst_rdy = '0; bus.ch_in_data = '0;
        bus.ch_in_sof = '0; bus.ch_in_eof = '0; bus.ch_in_src_rdy = '0; bus.out_dst_rdy = 1'b0;
        for (int c = 0; c < 6; c++) begin pos[c] = 0; len[c] = 0; end
    endtask

    initial begin
        //          sof   eof   src   addr   data    rdy    dst   wen    osrc   osof   oeof   drop
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 4'd3, 8'hA0, 6'h3F, 1'b1, 6'h04, 6'h04, 6'h04, 6'h00, 16'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 4'd9, 8'hA1, 6'h3F, 1'b1, 6'h04, 6'h04, 6'h00, 6'h00, 16'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 4'd9, 8'hA2, 6'h3F, 1'b1, 6'h04, 6'h04, 6'h00, 6'h00, 16'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 4'd9, 8'hA3, 6'h3F, 1'b1, 6'h04, 6'h04, 6'h00, 6'h04, 16'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 4'd3, 8'h00, 6'h3F, 1'b0, 6'h00, 6'h00, 6'h00, 6'h00, 16'd0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 4'd9, 8'hB0, 6'h3F, 1'b1, 6'h00, 6'h00, 6'h00, 6'h00, 16'd0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 4'd3, 8'hB1, 6'h3F, 1'b1, 6'h00, 6'h00, 6'h00, 6'h00, 16'd1};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 4'd3, 8'hB2, 6'h3F, 1'b1, 6'h00, 6'h00, 6'h00, 6'h00, 16'd1};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 4'd0, 8'hC0, 6'h3F, 1'b1, 6'h00, 6'h00, 6'h00, 6'h00, 16'd1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 4'd3, 8'hC1, 6'h3F, 1'b1, 6'h00, 6'h00, 6'h00, 6'h00, 16'd2};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 4'd1, 8'hD0, 6'h3E, 1'b0, 6'h01, 6'h01, 6'h01, 6'h01, 16'd2};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 4'd1, 8'hD0, 6'h3E, 1'b0, 6'h01, 6'h01, 6'h01, 6'h01, 16'd2};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 4'd1, 8'hD0, 6'h3F, 1'b1, 6'h01, 6'h01, 6'h01, 6'h01, 16'd2};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 4'd1, 8'h00, 6'h3F, 1'b0, 6'h00, 6'h00, 6'h00, 6'h00, 16'd2};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 4'd6, 8'hE0, 6'h3F, 1'b1, 6'h20, 6'h20, 6'h20, 6'h00, 16'd2};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 4'd6, 8'hE1, 6'h1F, 1'b0, 6'h20, 6'h20, 6'h00, 6'h00, 16'd2};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 4'd6, 8'hE2, 6'h3F, 1'b1, 6'h20, 6'h20, 6'h00, 6'h20, 16'd2};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 6'h3F, 1'b0, 6'h00, 6'h00, 6'h00, 6'h00, 16'd2};

        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_idle("reset");

        // downstream routing, drop, stall and single-beat vectors
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            bus.in_sof = tbl[i].sof; bus.in_eof = tbl[i].eof; bus.in_src_rdy = tbl[i].src;
            bus.inport_addr = tbl[i].addr; bus.in_data = tbl[i].data; bus.ch_out_dst_rdy = tbl[i].rdy;
            #1;
            chk($sformatf("v%0d in_dst_rdy", i), 64'(bus.in_dst_rdy), 64'(tbl[i].dst));
            chk($sformatf("v%0d wenables", i), 64'(bus.wenables), 64'(tbl[i].wen));
            chk($sformatf("v%0d ch_out_src_rdy", i), 64'(bus.ch_out_src_rdy), 64'(tbl[i].osrc));
            chk($sformatf("v%0d ch_out_sof", i), 64'(bus.ch_out_sof), 64'(tbl[i].osof));
            chk($sformatf("v%0d ch_out_eof", i), 64'(bus.ch_out_eof), 64'(tbl[i].oeof));
            chk($sformatf("v%0d ch_out_data", i), 64'(bus.ch_out_data), 64'({6{tbl[i].data}}));
            chk($sformatf("v%0d drop_count", i), 64'(bus.drop_count), 64'(tbl[i].drop));
        end

        // drop counter saturation with back-to-back single-beat invalid frames
        @(negedge clk);
        bus.in_sof = 1'b1; bus.in_eof = 1'b1; bus.in_src_rdy = 1'b1; bus.inport_addr = 4'd9;
        repeat (65532) @(posedge clk);
        @(negedge clk);
        chk("drop_count near max", 64'(bus.drop_count), 64'hFFFE);
        @(negedge clk);
        chk("drop_count reaches max", 64'(bus.drop_count), 64'hFFFF);
        repeat (5) @(negedge clk);
        chk("drop_count saturated", 64'(bus.drop_count), 64'hFFFF);
        bus.in_src_rdy = 1'b0; bus.in_sof = 1'b0; bus.in_eof = 1'b0;

        // channels 0, 2 and 5 each hold a 3-byte frame
        len[0] = 3; len[2] = 3; len[5] = 3;
        lg.delete(); ex.delete(); cyc = 0;
        for (int f = 0; f < 3; f++)
            for (int b = 0; b < 3; b++)
                add_beat(1 + 4*f + b, (f == 0) ? 0 : (f == 1) ? 2 : 5, b, b == 0, b == 2);
        repeat (14) up_step(1'b1);
        cmp_log("rr3");

        // platform stall mid-frame on channel 2 while channel 4 waits
        pos[2] = 0; len[2] = 5; pos[4] = 0; len[4] = 3;
        lg.delete(); ex.delete(); cyc = 0;
        add_beat(1, 2, 0, 1'b1, 1'b0); add_beat(2, 2, 1, 1'b0, 1'b0);
        add_beat(7, 2, 2, 1'b0, 1'b0); add_beat(8, 2, 3, 1'b0, 1'b0);
        add_beat(9, 2, 4, 1'b0, 1'b1);
        for (int b = 0; b < 3; b++) add_beat(11 + b, 4, b, b == 0, b == 2);
        for (int i = 0; i < 16; i++) begin
            up_step(!(i >= 3 && i <= 6));
            if (i >= 3 && i <= 6) begin
                chk($sformatf("stall%0d renables", i), 64'(last_ren), 64'h04);
                chk($sformatf("stall%0d outport_addr", i), 64'(last_oaddr), 64'd3);
                chk($sformatf("stall%0d out_src_rdy", i), 64'(last_osrc), 64'd1);
            end
        end
        cmp_log("stall");

        // reset in the middle of a downstream and an upstream frame
        @(negedge clk);
        bus.in_sof = 1'b1; bus.in_eof = 1'b0; bus.in_src_rdy = 1'b1; bus.inport_addr = 4'd2;
        bus.in_data = 8'hF0; bus.ch_out_dst_rdy = 6'h3F;
        @(negedge clk);
        bus.in_src_rdy = 1'b0; bus.in_sof = 1'b0;
        pos[3] = 0; len[3] = 4;
        up_step(1'b1);
        up_step(1'b1);
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_idle("midframe reset");
        bus.in_src_rdy = 1'b1; bus.in_sof = 1'b0; bus.inport_addr = 4'd2; bus.ch_out_dst_rdy = 6'h3F;
        #1;
        chk("post-reset body beat in_dst_rdy", 64'(bus.in_dst_rdy), 64'd1);
        chk("post-reset body beat wenables", 64'(bus.wenables), 64'd0);
        @(negedge clk);
        bus.in_src_rdy = 1'b0;
        len[0] = 2; len[5] = 2;
        lg.delete(); ex.delete(); cyc = 0;
        add_beat(1, 0, 0, 1'b1, 1'b0); add_beat(2, 0, 1, 1'b0, 1'b1);
        add_beat(4, 5, 0, 1'b1, 1'b0); add_beat(5, 5, 1, 1'b0, 1'b1);
        repeat (8) up_step(1'b1);
        cmp_log("post-reset rr");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
